// File: rtl/dcache_responder_pkg.sv
// Shared encodings for the data-cache responder.
// Flush bit index, access lengths, FSM states.
package dcache_responder_pkg;

  localparam int CTRL_FLUSH = 0;

  localparam logic [1:0] WLEN_BYTE = 2'b00;
  localparam logic [1:0] WLEN_HALF = 2'b01;
  localparam logic [1:0] WLEN_WORD = 2'b10;

  typedef enum logic [1:0] {
    DCR_IDLE = 2'd0,
    DCR_REQ  = 2'd1,
    DCR_WAIT = 2'd2,
    DCR_RESP = 2'd3
  } dcr_state_t;

  function automatic logic bad_access(
    input logic [1:0] wlen,
    input logic [1:0] off
  );
    logic bad;
    bad = 1'b1;
    unique case (wlen)
      WLEN_BYTE: bad = 1'b0;
      WLEN_HALF: bad = off[0];
      WLEN_WORD: bad = |off;
      default:   bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/dcache_lane_align.sv
// Byte-lane steering: write strobes/replication and
// read right-justify plus length mask.
module dcache_lane_align
  import dcache_responder_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [1:0]        off,
  input  logic [1:0]        wlen,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] rdata,
  output logic [3:0]        wstrb,
  output logic [DATA_W-1:0] wdata_sh,
  output logic [DATA_W-1:0] rdata_al
);

  logic [DATA_W-1:0] mask;

  always_comb begin
    wstrb    = 4'b1111;
    wdata_sh = wdata;
    mask     = '1;
    unique case (wlen)
      WLEN_BYTE: begin
        wstrb    = 4'b0001 << off;
        wdata_sh = {4{wdata[7:0]}};
        mask     = 32'h0000_00ff;
      end
      WLEN_HALF: begin
        wstrb    = 4'b0011 << off;
        wdata_sh = {2{wdata[15:0]}};
        mask     = 32'h0000_ffff;
      end
      default: begin
        wstrb    = 4'b1111;
        wdata_sh = wdata;
        mask     = '1;
      end
    endcase
    rdata_al = (rdata >> {off, 3'b000}) & mask;
  end

endmodule

// File: rtl/dcache_responder.sv
// Core data-cache request to req/gnt/rvalid bus bridge.
// One outstanding transaction; flush drops or aborts it.
module dcache_responder
  import dcache_responder_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int CTRL_W  = 6,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CTRL_W-1:0] ctrl_signal_i,
  input  logic              req_valid_i,
  input  logic              wen_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [1:0]        wlen_i,
  output logic              ready_o,
  output logic              data_valid_o,
  output logic [DATA_W-1:0] data_o,
  output logic              error_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic [3:0]        mem_wstrb_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  dcr_state_t        state;
  logic [CNT_W-1:0]  cnt;
  logic              drop;
  logic              err_q;
  logic              wen_q;
  logic              req_q;
  logic              dv_q;
  logic              er_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [1:0]        wlen_q;
  logic [3:0]        strb;
  logic [DATA_W-1:0] wd_sh;
  logic [DATA_W-1:0] rd_al;
  logic              flush;

  assign flush = ctrl_signal_i[CTRL_FLUSH];

  dcache_lane_align #(
    .DATA_W(DATA_W)
  ) u_align (
    .off     (addr_q[1:0]),
    .wlen    (wlen_q),
    .wdata   (wdata_q),
    .rdata   (mem_rdata_i),
    .wstrb   (strb),
    .wdata_sh(wd_sh),
    .rdata_al(rd_al)
  );

  // Bus fields are only meaningful while the request is up.
  assign mem_req_o    = req_q;
  assign mem_we_o     = req_q & wen_q;
  assign mem_addr_o   = req_q ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
  assign mem_wdata_o  = req_q ? wd_sh : '0;
  assign mem_wstrb_o  = req_q ? strb : 4'b0000;
  assign data_valid_o = dv_q & ~flush;
  assign error_o      = er_q & ~flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= DCR_IDLE;
      cnt     <= '0;
      drop    <= 1'b0;
      err_q   <= 1'b0;
      wen_q   <= 1'b0;
      req_q   <= 1'b0;
      dv_q    <= 1'b0;
      er_q    <= 1'b0;
      ready_o <= 1'b1;
      data_o  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wlen_q  <= 2'b00;
    end else begin
      unique case (state)
        DCR_IDLE: begin
          if (req_valid_i && !flush) begin
            addr_q  <= addr_i;
            wen_q   <= wen_i;
            wdata_q <= wdata_i;
            wlen_q  <= wlen_i;
            err_q   <= bad_access(wlen_i, addr_i[1:0]);
            req_q   <= !bad_access(wlen_i, addr_i[1:0]);
            ready_o <= 1'b0;
            drop    <= 1'b0;
            cnt     <= '0;
            state   <= DCR_REQ;
          end
        end
        DCR_REQ: begin
          if (req_q && mem_gnt_i) begin
            req_q <= 1'b0;
            drop  <= flush;
            cnt   <= '0;
            state <= DCR_WAIT;
          end else if (flush) begin
            req_q   <= 1'b0;
            ready_o <= 1'b1;
            cnt     <= '0;
            state   <= DCR_IDLE;
          end else if (err_q || cnt == CNT_LAST) begin
            req_q  <= 1'b0;
            dv_q   <= 1'b1;
            er_q   <= 1'b1;
            data_o <= '0;
            cnt    <= '0;
            state  <= DCR_RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DCR_WAIT: begin
          if (mem_rvalid_i || cnt == CNT_LAST) begin
            cnt  <= '0;
            drop <= 1'b0;
            if (drop || flush) begin
              ready_o <= 1'b1;
              state   <= DCR_IDLE;
            end else begin
              dv_q   <= 1'b1;
              er_q   <= !mem_rvalid_i;
              data_o <= mem_rvalid_i ? rd_al : '0;
              state  <= DCR_RESP;
            end
          end else begin
            cnt <= cnt + 1'b1;
            if (flush) drop <= 1'b1;
          end
        end
        DCR_RESP: begin
          dv_q    <= 1'b0;
          er_q    <= 1'b0;
          ready_o <= 1'b1;
          state   <= DCR_IDLE;
        end
        default: state <= DCR_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_responder.sv
// Directed bench for dcache_responder with a hand-driven
// memory side and hand-computed expectations.
module tb_dcache_responder;
  import dcache_responder_pkg::*;

  logic        clk;
  logic        rst;
  logic [5:0]  ctrl;
  logic        req_valid;
  logic        wen;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [1:0]  wlen;
  logic        ready;
  logic        dv;
  logic [31:0] rdata_o;
  logic        err;
  logic        mreq;
  logic        mwe;
  logic [31:0] maddr;
  logic [31:0] mwdata;
  logic [3:0]  mstrb;
  logic        gnt;
  logic        rvalid;
  logic [31:0] mrdata;

  int n_checks = 0;
  int n_fail   = 0;

  dcache_responder dut (
    .clk          (clk),
    .rst          (rst),
    .ctrl_signal_i(ctrl),
    .req_valid_i  (req_valid),
    .wen_i        (wen),
    .addr_i       (addr),
    .wdata_i      (wdata),
    .wlen_i       (wlen),
    .ready_o      (ready),
    .data_valid_o (dv),
    .data_o       (rdata_o),
    .error_o      (err),
    .mem_req_o    (mreq),
    .mem_we_o     (mwe),
    .mem_addr_o   (maddr),
    .mem_wdata_o  (mwdata),
    .mem_wstrb_o  (mstrb),
    .mem_gnt_i    (gnt),
    .mem_rvalid_i (rvalid),
    .mem_rdata_i  (mrdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic        w,
                        input logic [31:0] a,
                        input logic [31:0] d,
                        input logic [1:0]  l);
    req_valid = 1'b1;
    wen       = w;
    addr      = a;
    wdata     = d;
    wlen      = l;
    check("acc_ready", {31'b0, ready}, 32'd1);
    tick;
    req_valid = 1'b0;
  endtask

  task automatic serve(input logic [31:0] word);
    gnt = 1'b1;
    tick;
    gnt = 1'b0;
    check("req_drop", {31'b0, mreq}, 32'd0);
    rvalid = 1'b1;
    mrdata = word;
    tick;
    rvalid = 1'b0;
  endtask

  int lat;

  initial begin
    rst = 1'b1; ctrl = '0; req_valid = 0; wen = 0;
    addr = '0; wdata = '0; wlen = 2'b00;
    gnt = 0; rvalid = 0; mrdata = '0;
    #12;
    check("rst_ready", {31'b0, ready}, 32'd1);
    check("rst_dv", {31'b0, dv}, 32'd0);
    check("rst_req", {31'b0, mreq}, 32'd0);
    check("rst_data", rdata_o, 32'd0);
    rst = 1'b0;
    tick;

    // word read, minimum latency
    accept(1'b0, 32'h8000_0010, 32'h0, WLEN_WORD);
    check("wr_req", {31'b0, mreq}, 32'd1);
    check("wr_addr", maddr, 32'h8000_0010);
    check("wr_we", {31'b0, mwe}, 32'd0);
    check("wr_busy", {31'b0, ready}, 32'd0);
    serve(32'hDEAD_BEEF);
    check("wr_dv", {31'b0, dv}, 32'd1);
    check("wr_data", rdata_o, 32'hDEAD_BEEF);
    check("wr_err", {31'b0, err}, 32'd0);
    tick;
    check("wr_dv_end", {31'b0, dv}, 32'd0);
    check("wr_idle", {31'b0, ready}, 32'd1);

    // byte write to lane 3
    accept(1'b1, 32'h8000_0013, 32'h0000_00A5, WLEN_BYTE);
    check("bw_strb", {28'b0, mstrb}, 32'h8);
    check("bw_lane", {24'b0, mwdata[31:24]}, 32'hA5);
    check("bw_we", {31'b0, mwe}, 32'd1);
    check("bw_addr", maddr, 32'h8000_0010);
    serve(32'h0);
    check("bw_dv", {31'b0, dv}, 32'd1);
    check("bw_err", {31'b0, err}, 32'd0);
    tick;
    check("bw_dv_end", {31'b0, dv}, 32'd0);

    // half read, upper half
    accept(1'b0, 32'h8000_0002, 32'h0, WLEN_HALF);
    check("hr_addr", maddr, 32'h8000_0000);
    serve(32'h1234_ABCD);
    check("hr_dv", {31'b0, dv}, 32'd1);
    check("hr_data", rdata_o, 32'h0000_1234);
    tick;

    // byte read lane 1, masked
    accept(1'b0, 32'h8000_0005, 32'h0, WLEN_BYTE);
    serve(32'h1234_ABCD);
    check("br_data", rdata_o, 32'h0000_00AB);
    tick;

    // misaligned half: no bus traffic
    accept(1'b0, 32'h8000_0003, 32'h0, WLEN_HALF);
    check("ma_noreq", {31'b0, mreq}, 32'd0);
    check("ma_dv_early", {31'b0, dv}, 32'd0);
    tick;
    check("ma_dv", {31'b0, dv}, 32'd1);
    check("ma_err", {31'b0, err}, 32'd1);
    tick;
    check("ma_dv_end", {31'b0, dv}, 32'd0);
    check("ma_idle", {31'b0, ready}, 32'd1);

    // illegal length at aligned address
    accept(1'b0, 32'h8000_0004, 32'h0, 2'b11);
    check("il_noreq", {31'b0, mreq}, 32'd0);
    tick;
    check("il_err", {31'b0, err}, 32'd1);
    tick;

    // flush in IDLE ignores the request
    ctrl[CTRL_FLUSH] = 1'b1;
    req_valid = 1'b1;
    tick;
    req_valid = 1'b0;
    ctrl[CTRL_FLUSH] = 1'b0;
    check("fi_ready", {31'b0, ready}, 32'd1);
    check("fi_noreq", {31'b0, mreq}, 32'd0);

    // flush in REQ aborts silently
    accept(1'b0, 32'h8000_0020, 32'h0, WLEN_WORD);
    ctrl[CTRL_FLUSH] = 1'b1;
    tick;
    ctrl[CTRL_FLUSH] = 1'b0;
    check("fr_ready", {31'b0, ready}, 32'd1);
    check("fr_noreq", {31'b0, mreq}, 32'd0);
    check("fr_dv", {31'b0, dv}, 32'd0);

    // flush in WAIT, rvalid five cycles later
    accept(1'b0, 32'h8000_0030, 32'h0, WLEN_WORD);
    gnt = 1'b1;
    tick;
    gnt = 1'b0;
    ctrl[CTRL_FLUSH] = 1'b1;
    tick;
    ctrl[CTRL_FLUSH] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("fw_wait_dv", {31'b0, dv}, 32'd0);
      tick;
    end
    rvalid = 1'b1;
    mrdata = 32'h5555_5555;
    tick;
    rvalid = 1'b0;
    check("fw_dv", {31'b0, dv}, 32'd0);
    check("fw_ready", {31'b0, ready}, 32'd1);

    // flush during RESP suppresses the pulse
    accept(1'b0, 32'h8000_0040, 32'h0, WLEN_WORD);
    serve(32'h55AA_55AA);
    ctrl[CTRL_FLUSH] = 1'b1;
    #1;
    check("fs_dv", {31'b0, dv}, 32'd0);
    ctrl[CTRL_FLUSH] = 1'b0;
    tick;
    check("fs_ready", {31'b0, ready}, 32'd1);

    // gnt withheld until timeout
    accept(1'b0, 32'h8000_0050, 32'h0, WLEN_WORD);
    check("to_req", {31'b0, mreq}, 32'd1);
    lat = 1;
    while (dv !== 1'b1 && lat < 400) begin
      tick;
      lat++;
    end
    check("to_lat", lat, 32'd256);
    check("to_err", {31'b0, err}, 32'd1);
    check("to_noreq", {31'b0, mreq}, 32'd0);
    check("to_data", rdata_o, 32'd0);
    tick;
    check("to_dv_end", {31'b0, dv}, 32'd0);

    // async reset mid-WAIT
    accept(1'b0, 32'h8000_0060, 32'h0, WLEN_WORD);
    gnt = 1'b1;
    tick;
    gnt = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("ar_ready", {31'b0, ready}, 32'd1);
    check("ar_req", {31'b0, mreq}, 32'd0);
    check("ar_dv", {31'b0, dv}, 32'd0);
    tick;
    rst = 1'b0;
    rvalid = 1'b1;
    tick;
    rvalid = 1'b0;
    check("ar_stray_dv", {31'b0, dv}, 32'd0);
    check("ar_idle", {31'b0, ready}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
